// File: rtl/accel_msg_ingress_buffer.sv
// Store-and-forward flit buffer between the NoC port and a custom accelerator.
// A flit is presented downstream only once its whole message is buffered.
package accel_msg_ingress_pkg;
  typedef struct packed {
    logic        notFinalFlit;
    logic        isIdleToken;
    logic [31:0] payload;
  } flit_t;
endpackage

module accel_msg_ingress_buffer
  import accel_msg_ingress_pkg::*;
#(
  parameter int LOG_DEPTH     = 4,
  parameter int MAX_MSG_FLITS = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  input  flit_t              in_data,
  input  logic               in_valid,
  output logic               in_ready,
  output flit_t              out_data,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [LOG_DEPTH:0] msg_count,
  output logic [LOG_DEPTH:0] level,
  output logic               err_overlong
);

  localparam int PW    = LOG_DEPTH + 1;
  localparam int DEPTH = 1 << LOG_DEPTH;
  localparam logic [PW-1:0] DEPTH_P    = PW'(DEPTH);
  localparam logic [PW-1:0] LAST_LEN_P = PW'(MAX_MSG_FLITS - 1);

  flit_t             mem_q [DEPTH];
  logic [PW-1:0]     wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]     rd_ptr_q, rd_ptr_d;
  logic [PW-1:0]     msg_count_q, msg_count_d;
  logic [PW-1:0]     cur_len_q, cur_len_d;
  logic              err_q, err_d;

  logic              full;
  logic              push, pop;
  logic              truncate;
  logic              msg_close, pop_final;
  flit_t             wr_flit;

  always_comb begin
    level     = wr_ptr_q - rd_ptr_q;
    full      = (level == DEPTH_P);
    in_ready  = !full;
    out_valid = (msg_count_q != '0);
    out_data  = mem_q[rd_ptr_q[LOG_DEPTH-1:0]];
    push      = in_valid && in_ready;
    pop       = out_valid && out_ready;
  end

  // A message that reaches the length limit is cut short by forcing its last flit final.
  always_comb begin
    truncate = in_data.notFinalFlit && (cur_len_q == LAST_LEN_P);
    wr_flit  = in_data;
    if (truncate) begin
      wr_flit.notFinalFlit = 1'b0;
    end
    msg_close = push && !wr_flit.notFinalFlit;
    pop_final = pop && !out_data.notFinalFlit;
  end

  always_comb begin
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    cur_len_d   = cur_len_q;
    err_d       = err_q;
    msg_count_d = msg_count_q;
    if (push) begin
      wr_ptr_d = wr_ptr_q + 1'b1;
      if (!wr_flit.notFinalFlit) begin
        cur_len_d = '0;
      end else begin
        cur_len_d = cur_len_q + 1'b1;
      end
      if (truncate) begin
        err_d = 1'b1;
      end
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + 1'b1;
    end
    case ({msg_close, pop_final})
      2'b10:   msg_count_d = msg_count_q + 1'b1;
      2'b01:   msg_count_d = msg_count_q - 1'b1;
      default: msg_count_d = msg_count_q;
    endcase
  end

  always_ff @(negedge clk) begin
    if (!rst_n) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      msg_count_q <= '0;
      cur_len_q   <= '0;
      err_q       <= 1'b0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      msg_count_q <= msg_count_d;
      cur_len_q   <= cur_len_d;
      err_q       <= err_d;
    end
  end

  // Storage is not cleared on reset; the pointers and message count gate visibility.
  always_ff @(negedge clk) begin
    if (rst_n && push) begin
      mem_q[wr_ptr_q[LOG_DEPTH-1:0]] <= wr_flit;
    end
  end

  assign msg_count    = msg_count_q;
  assign err_overlong = err_q;

endmodule

// File: tb/tb_accel_msg_ingress_buffer.sv
// Self-checking bench for accel_msg_ingress_buffer: vector table for the basic
// push/pop behaviour, hand-written sequences and a reference queue for the rest.
module tb_accel_msg_ingress_buffer;
  import accel_msg_ingress_pkg::*;

  localparam int LOG_DEPTH     = 4;
  localparam int MAX_MSG_FLITS = 4;

  logic               clk = 1'b0;
  logic               rst_n;
  flit_t              in_data;
  logic               in_valid;
  logic               in_ready;
  flit_t              out_data;
  logic               out_valid;
  logic               out_ready;
  logic [LOG_DEPTH:0] msg_count;
  logic [LOG_DEPTH:0] level;
  logic               err_overlong;

  int checks   = 0;
  int failures = 0;

  flit_t       ref_q[$];
  logic [31:0] rx_q[$];
  int          model_len = 0;
  flit_t       exp_f;
  flit_t       st_f;

  typedef struct {
    logic        in_valid;
    logic        nff;
    logic [31:0] payload;
    logic        out_ready;
    logic        exp_in_ready;
    logic        exp_out_valid;
    int          exp_msg;
    int          exp_level;
    logic [31:0] exp_payload;
  } vec_t;

  vec_t vecs[8];

  accel_msg_ingress_buffer #(
    .LOG_DEPTH    (LOG_DEPTH),
    .MAX_MSG_FLITS(MAX_MSG_FLITS)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .in_data     (in_data),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .out_data    (out_data),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .msg_count   (msg_count),
    .level       (level),
    .err_overlong(err_overlong)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s actual=%0h expected=%0h", name, actual, expected);
    end
  endtask

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic v, input logic nff, input logic [31:0] p, input logic ordy);
    in_valid             = v;
    in_data.notFinalFlit = nff;
    in_data.isIdleToken  = 1'b0;
    in_data.payload      = p;
    out_ready            = ordy;
    tick();
  endtask

  task automatic drainAll(input string name, input int budget);
    int n;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    n = 0;
    while ((level != 0) && (n < budget)) begin
      tick();
      n++;
    end
    out_ready = 1'b0;
    checkOutput({name, "_drained_level"}, 64'(level), 64'd0);
    checkOutput({name, "_drained_msgs"}, 64'(msg_count), 64'd0);
  endtask

  // Reference queue: sampled on the inactive edge, when inputs and outputs are stable.
  always @(posedge clk) begin
    if (!rst_n) begin
      ref_q.delete();
      model_len = 0;
    end else begin
      if (out_valid && out_ready) begin
        if (ref_q.size() == 0) begin
          checks++;
          failures++;
          $display("[TB] FAIL pop_order actual=%0h expected=<empty>", out_data);
        end else begin
          exp_f = ref_q.pop_front();
          checkOutput("pop_order", 64'(out_data), 64'(exp_f));
        end
        rx_q.push_back(out_data.payload);
      end
      if (in_valid && in_ready) begin
        st_f = in_data;
        if (in_data.notFinalFlit && (model_len == MAX_MSG_FLITS - 1)) begin
          st_f.notFinalFlit = 1'b0;
          model_len = 0;
        end else if (!in_data.notFinalFlit) begin
          model_len = 0;
        end else begin
          model_len++;
        end
        ref_q.push_back(st_f);
      end
    end
  end

  initial begin
    flit_t pend[$];
    flit_t f;
    int    len;
    int    n;
    logic  acc;

    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_data   = '0;
    out_ready = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;

    checkOutput("rst_in_ready", 64'(in_ready), 64'd1);
    checkOutput("rst_out_valid", 64'(out_valid), 64'd0);
    checkOutput("rst_level", 64'(level), 64'd0);
    checkOutput("rst_msg_count", 64'(msg_count), 64'd0);
    checkOutput("rst_err", 64'(err_overlong), 64'd0);

    // in_valid, nff, payload, out_ready | in_ready, out_valid, msgs, level, head payload
    vecs[0] = '{1'b1, 1'b0, 32'hCAFE, 1'b0, 1'b1, 1'b1, 1, 1, 32'hCAFE};
    vecs[1] = '{1'b0, 1'b0, 32'h0,    1'b1, 1'b1, 1'b0, 0, 0, 32'h0};
    vecs[2] = '{1'b1, 1'b1, 32'hA,    1'b1, 1'b1, 1'b0, 0, 1, 32'h0};
    vecs[3] = '{1'b1, 1'b1, 32'hB,    1'b1, 1'b1, 1'b0, 0, 2, 32'h0};
    vecs[4] = '{1'b1, 1'b0, 32'hC,    1'b1, 1'b1, 1'b1, 1, 3, 32'hA};
    vecs[5] = '{1'b0, 1'b0, 32'h0,    1'b1, 1'b1, 1'b1, 1, 2, 32'hB};
    vecs[6] = '{1'b0, 1'b0, 32'h0,    1'b1, 1'b1, 1'b1, 1, 1, 32'hC};
    vecs[7] = '{1'b0, 1'b0, 32'h0,    1'b1, 1'b1, 1'b0, 0, 0, 32'h0};

    for (int i = 0; i < 8; i++) begin
      applyStimulus(vecs[i].in_valid, vecs[i].nff, vecs[i].payload, vecs[i].out_ready);
      checkOutput($sformatf("vec%0d_in_ready", i), 64'(in_ready), 64'(vecs[i].exp_in_ready));
      checkOutput($sformatf("vec%0d_out_valid", i), 64'(out_valid), 64'(vecs[i].exp_out_valid));
      checkOutput($sformatf("vec%0d_msg_count", i), 64'(msg_count), 64'(vecs[i].exp_msg));
      checkOutput($sformatf("vec%0d_level", i), 64'(level), 64'(vecs[i].exp_level));
      checkOutput($sformatf("vec%0d_err", i), 64'(err_overlong), 64'd0);
      if (vecs[i].exp_out_valid) begin
        checkOutput($sformatf("vec%0d_payload", i), 64'(out_data.payload), 64'(vecs[i].exp_payload));
      end
    end
    in_valid  = 1'b0;
    out_ready = 1'b0;

    $display("[TB] fill to full, hold a 17th flit, then drain");
    rx_q.delete();
    for (int i = 0; i < 16; i++) begin
      applyStimulus(1'b1, 1'b0, 32'd100 + 32'(i), 1'b0);
    end
    checkOutput("t3_full_level", 64'(level), 64'd16);
    checkOutput("t3_full_msgs", 64'(msg_count), 64'd16);
    checkOutput("t3_full_in_ready", 64'(in_ready), 64'd0);
    applyStimulus(1'b1, 1'b0, 32'd200, 1'b0);
    applyStimulus(1'b1, 1'b0, 32'd200, 1'b0);
    checkOutput("t3_held_level", 64'(level), 64'd16);
    checkOutput("t3_held_in_ready", 64'(in_ready), 64'd0);
    out_ready = 1'b1;
    n = 0;
    while ((rx_q.size() < 17) && (n < 60)) begin
      acc = in_valid && in_ready;
      tick();
      if (acc) in_valid = 1'b0;
      n++;
    end
    out_ready = 1'b0;
    in_valid  = 1'b0;
    checkOutput("t3_rx_count", 64'(rx_q.size()), 64'd17);
    for (int i = 0; i < 17 && i < rx_q.size(); i++) begin
      checkOutput($sformatf("t3_rx%0d", i), 64'(rx_q[i]), (i < 16) ? 64'(100 + i) : 64'd200);
    end
    checkOutput("t3_level_after", 64'(level), 64'd0);

    $display("[TB] overlong message truncation");
    for (int i = 0; i < 4; i++) begin
      applyStimulus(1'b1, 1'b1, 32'h40 + 32'(i), 1'b0);
    end
    checkOutput("t4_msgs_after4", 64'(msg_count), 64'd1);
    checkOutput("t4_err_after4", 64'(err_overlong), 64'd1);
    checkOutput("t4_level_after4", 64'(level), 64'd4);
    applyStimulus(1'b1, 1'b1, 32'h44, 1'b0);
    checkOutput("t4_msgs_after5", 64'(msg_count), 64'd1);
    checkOutput("t4_level_after5", 64'(level), 64'd5);
    applyStimulus(1'b1, 1'b0, 32'h45, 1'b0);
    checkOutput("t4_msgs_closed", 64'(msg_count), 64'd2);
    in_valid = 1'b0;
    for (int i = 0; i < 4; i++) begin
      checkOutput($sformatf("t4_pop%0d_payload", i), 64'(out_data.payload), 64'(32'h40 + i));
      checkOutput($sformatf("t4_pop%0d_nff", i), 64'(out_data.notFinalFlit), (i == 3) ? 64'd0 : 64'd1);
      applyStimulus(1'b0, 1'b0, 32'h0, 1'b1);
    end
    out_ready = 1'b0;
    checkOutput("t4_msgs_second", 64'(msg_count), 64'd1);
    checkOutput("t4_level_second", 64'(level), 64'd2);
    checkOutput("t4_head_second", 64'(out_data.payload), 64'h44);
    drainAll("t4", 10);
    checkOutput("t4_err_sticky", 64'(err_overlong), 64'd1);

    $display("[TB] simultaneous close and final pop");
    applyStimulus(1'b1, 1'b0, 32'h50, 1'b0);
    applyStimulus(1'b1, 1'b1, 32'h51, 1'b0);
    checkOutput("t5_msgs_before", 64'(msg_count), 64'd1);
    applyStimulus(1'b1, 1'b0, 32'h52, 1'b1);
    checkOutput("t5_msgs_same", 64'(msg_count), 64'd1);
    checkOutput("t5_level_same", 64'(level), 64'd2);
    checkOutput("t5_head", 64'(out_data.payload), 64'h51);
    drainAll("t5", 10);

    $display("[TB] 40 random messages across pointer wrap");
    for (int m = 0; m < 40; m++) begin
      len = $urandom_range(1, 4);
      for (int k = 0; k < len; k++) begin
        f.notFinalFlit = (k != len - 1);
        f.isIdleToken  = 1'($urandom_range(0, 1));
        f.payload      = $urandom;
        pend.push_back(f);
      end
    end
    n = 0;
    while (((pend.size() > 0) || (ref_q.size() > 0)) && (n < 3000)) begin
      in_valid  = (pend.size() > 0) && ($urandom_range(0, 3) != 0);
      if (pend.size() > 0) in_data = pend[0];
      out_ready = ($urandom_range(0, 2) != 0);
      acc = in_valid && in_ready;
      tick();
      if (acc) void'(pend.pop_front());
      n++;
    end
    in_valid  = 1'b0;
    out_ready = 1'b0;
    checkOutput("t5_rand_pending", 64'(pend.size()), 64'd0);
    checkOutput("t5_rand_ref_empty", 64'(ref_q.size()), 64'd0);
    checkOutput("t5_rand_level", 64'(level), 64'd0);
    checkOutput("t5_rand_msgs", 64'(msg_count), 64'd0);
    checkOutput("t5_err_still", 64'(err_overlong), 64'd1);

    $display("[TB] reset in the middle of a message");
    applyStimulus(1'b1, 1'b1, 32'h60, 1'b0);
    applyStimulus(1'b1, 1'b1, 32'h61, 1'b0);
    checkOutput("t6_level_partial", 64'(level), 64'd2);
    checkOutput("t6_msgs_partial", 64'(msg_count), 64'd0);
    rst_n = 1'b0;
    applyStimulus(1'b0, 1'b0, 32'h0, 1'b0);
    rst_n = 1'b1;
    checkOutput("t6_rst_level", 64'(level), 64'd0);
    checkOutput("t6_rst_msgs", 64'(msg_count), 64'd0);
    checkOutput("t6_rst_out_valid", 64'(out_valid), 64'd0);
    checkOutput("t6_rst_in_ready", 64'(in_ready), 64'd1);
    checkOutput("t6_rst_err", 64'(err_overlong), 64'd0);
    applyStimulus(1'b1, 1'b0, 32'h66, 1'b0);
    checkOutput("t6_new_out_valid", 64'(out_valid), 64'd1);
    checkOutput("t6_new_msgs", 64'(msg_count), 64'd1);
    checkOutput("t6_new_payload", 64'(out_data.payload), 64'h66);
    checkOutput("t6_new_nff", 64'(out_data.notFinalFlit), 64'd0);
    applyStimulus(1'b0, 1'b0, 32'h0, 1'b1);
    out_ready = 1'b0;
    checkOutput("t6_final_level", 64'(level), 64'd0);
    checkOutput("t6_final_msgs", 64'(msg_count), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
